// File: rtl/updown_counter_mod.sv
// -----------------------------------------------------------------------------
// updown_counter_mod
//
// Parametrised up/down counter. It supports a configurable width, modulus and
// step size, wrap or saturate at the limits, a synchronous load and a count
// enable. The q, wrap and sat outputs are registered. at_max and at_min are
// decoded combinationally from the registered count.
//
// Parameters:
//   WIDTH     count width in bits (>= 2)
//   MAX_VAL   highest count value; counting is modulo MAX_VAL+1
//   RESET_VAL count value after reset (<= MAX_VAL)
//   SATURATE  0 = wrap at the limits, 1 = clamp at the limits
//
// Ports:
//   clk       clock, rising edge
//   reset     synchronous active-high reset
//   en        count enable
//   up_down   direction, 1 = up, 0 = down
//   step      increment/decrement amount (0 = hold, clamped to MAX_VAL)
//   load      synchronous load, has priority over en
//   load_val  value to load (clamped to MAX_VAL)
//   q         registered count
//   wrap      one-cycle pulse, the last update crossed a limit while wrapping
//   sat       one-cycle pulse, the last update was clamped at a limit
//   at_max    q == MAX_VAL
//   at_min    q == 0
// -----------------------------------------------------------------------------
module updown_counter_mod #(
  parameter int WIDTH     = 8,
  parameter int MAX_VAL   = 2**WIDTH - 1,
  parameter int RESET_VAL = 0,
  parameter int SATURATE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_down,
  input  logic [WIDTH-1:0] step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             sat,
  output logic             at_max,
  output logic             at_min
);

  // The arithmetic is one bit wider than the count. With this extra bit,
  // q + s and q + (MAX_VAL+1) never overflow. This holds even when
  // MAX_VAL = 2**WIDTH-1.
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MAX_VAL + 1);
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);
  localparam bit               SAT_EN  = (SATURATE != 0);

  logic [WIDTH-1:0] q_reg, q_next;
  logic             wrap_reg, wrap_next;
  logic             sat_reg, sat_next;

  logic [WIDTH:0] q_ext;
  logic [WIDTH:0] step_ext;
  logic [WIDTH:0] s_ext;
  logic [WIDTH:0] ld_ext;
  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] up_wrap_ext;
  logic [WIDTH:0] dn_ext;
  logic [WIDTH:0] dn_wrap_ext;

  always_comb begin
    q_ext    = {1'b0, q_reg};
    step_ext = {1'b0, step};
    ld_ext   = {1'b0, load_val};

    // Out-of-range step and load values are clamped to MAX_VAL.
    s_ext    = (step_ext > MAX_EXT) ? MAX_EXT : step_ext;
    if (ld_ext > MAX_EXT) begin
      ld_ext = MAX_EXT;
    end

    sum_ext     = q_ext + s_ext;
    up_wrap_ext = sum_ext - MOD_EXT;
    dn_ext      = q_ext - s_ext;
    dn_wrap_ext = q_ext + MOD_EXT - s_ext;

    q_next    = q_reg;
    wrap_next = 1'b0;
    sat_next  = 1'b0;

    if (load) begin
      q_next = ld_ext[WIDTH-1:0];
    end else if (en) begin
      if (up_down) begin
        // A sum equal to MAX_VAL is an exact landing and raises no flag.
        if (sum_ext > MAX_EXT) begin
          if (SAT_EN) begin
            q_next   = MAX_Q;
            sat_next = 1'b1;
          end else begin
            q_next    = up_wrap_ext[WIDTH-1:0];
            wrap_next = 1'b1;
          end
        end else begin
          q_next = sum_ext[WIDTH-1:0];
        end
      end else begin
        if (q_ext >= s_ext) begin
          q_next = dn_ext[WIDTH-1:0];
        end else if (SAT_EN) begin
          q_next   = '0;
          sat_next = 1'b1;
        end else begin
          q_next    = dn_wrap_ext[WIDTH-1:0];
          wrap_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg    <= RST_Q;
      wrap_reg <= 1'b0;
      sat_reg  <= 1'b0;
    end else begin
      q_reg    <= q_next;
      wrap_reg <= wrap_next;
      sat_reg  <= sat_next;
    end
  end

  assign q      = q_reg;
  assign wrap   = wrap_reg;
  assign sat    = sat_reg;
  assign at_max = (q_reg == MAX_Q);
  assign at_min = (q_reg == '0);

endmodule

// File: tb/tb_updown_counter_mod.sv
// -----------------------------------------------------------------------------
// tb_updown_counter_mod
//
// Six counter instances share one set of stimulus inputs. The instances use
// different MAX_VAL, SATURATE and RESET_VAL settings, and WIDTH is 4 for all
// of them. When a cycle's stimulus is driven, the expected result for each
// instance comes from an integer reference model and is pushed to a
// scoreboard queue. After the edge, the expected results are popped and
// compared. Directed steps from the test plan also carry constant
// expectations. After the directed steps, 2000 random cycles run.
// -----------------------------------------------------------------------------
module tb_updown_counter_mod;

  localparam int NI = 6;

  function automatic int cfg_max(input int i);
    case (i)
      0: return 15;
      1: return 9;
      2: return 9;
      3: return 15;
      4: return 5;
      default: return 5;
    endcase
  endfunction

  function automatic int cfg_sat(input int i);
    case (i)
      2, 3, 5: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int cfg_rv(input int i);
    case (i)
      0: return 0;
      1: return 2;
      2: return 7;
      3: return 0;
      4: return 5;
      default: return 1;
    endcase
  endfunction

  logic       clk = 1'b0;
  logic       reset, en, up_down, load;
  logic [3:0] step, load_val;

  logic [3:0] q_o      [NI];
  logic       wrap_o   [NI];
  logic       sat_o    [NI];
  logic       at_max_o [NI];
  logic       at_min_o [NI];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      updown_counter_mod #(
        .WIDTH    (4),
        .MAX_VAL  (cfg_max(gi)),
        .RESET_VAL(cfg_rv(gi)),
        .SATURATE (cfg_sat(gi))
      ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .up_down (up_down),
        .step    (step),
        .load    (load),
        .load_val(load_val),
        .q       (q_o[gi]),
        .wrap    (wrap_o[gi]),
        .sat     (sat_o[gi]),
        .at_max  (at_max_o[gi]),
        .at_min  (at_min_o[gi])
      );
    end
  endgenerate

  typedef struct {
    int q;
    bit w;
    bit s;
  } exp_t;

  exp_t sb[$];
  int   mq[NI];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus and push the model's expectations. Then wait
  // for the edge and pop and compare.
  task automatic run(input bit r, input bit ld, input bit e, input bit ud,
                     input int st, input int lv);
    exp_t x;
    int   m, s;
    reset    = r;
    load     = ld;
    en       = e;
    up_down  = ud;
    step     = st[3:0];
    load_val = lv[3:0];
    for (int i = 0; i < NI; i++) begin
      m   = cfg_max(i);
      x.w = 1'b0;
      x.s = 1'b0;
      if (r) begin
        mq[i] = cfg_rv(i);
      end else if (ld) begin
        mq[i] = (lv > m) ? m : lv;
      end else if (e) begin
        s = (st > m) ? m : st;
        if (ud) begin
          if (mq[i] + s > m) begin
            if (cfg_sat(i) != 0) begin
              mq[i] = m;
              x.s   = 1'b1;
            end else begin
              mq[i] = (mq[i] + s) % (m + 1);
              x.w   = 1'b1;
            end
          end else begin
            mq[i] = mq[i] + s;
          end
        end else begin
          if (s > mq[i]) begin
            if (cfg_sat(i) != 0) begin
              mq[i] = 0;
              x.s   = 1'b1;
            end else begin
              mq[i] = (mq[i] - s + m + 1) % (m + 1);
              x.w   = 1'b1;
            end
          end else begin
            mq[i] = mq[i] - s;
          end
        end
      end
      x.q = mq[i];
      sb.push_back(x);
    end

    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NI; i++) begin
      x = sb.pop_front();
      chk($sformatf("q[%0d]", i),      32'(q_o[i]),      32'(x.q));
      chk($sformatf("wrap[%0d]", i),   32'(wrap_o[i]),   32'(x.w));
      chk($sformatf("sat[%0d]", i),    32'(sat_o[i]),    32'(x.s));
      chk($sformatf("at_max[%0d]", i), 32'(at_max_o[i]), 32'(x.q == cfg_max(i)));
      chk($sformatf("at_min[%0d]", i), 32'(at_min_o[i]), 32'(x.q == 0));
      chk($sformatf("q_le_max[%0d]", i), 32'(int'(q_o[i]) <= cfg_max(i)), 32'd1);
      chk($sformatf("wrap_and_sat[%0d]", i), 32'(wrap_o[i] & sat_o[i]), 32'd0);
    end
    $display("cyc=%0d rst=%0b ld=%0b en=%0b ud=%0b step=%0d lv=%0d q=%0d,%0d,%0d,%0d,%0d,%0d w=%0b%0b%0b%0b%0b%0b s=%0b%0b%0b%0b%0b%0b",
             cyc, r, ld, e, ud, st, lv,
             q_o[0], q_o[1], q_o[2], q_o[3], q_o[4], q_o[5],
             wrap_o[0], wrap_o[1], wrap_o[2], wrap_o[3], wrap_o[4], wrap_o[5],
             sat_o[0], sat_o[1], sat_o[2], sat_o[3], sat_o[4], sat_o[5]);
  endtask

  initial begin
    reset    = 1'b1;
    load     = 1'b0;
    en       = 1'b0;
    up_down  = 1'b1;
    step     = 4'd1;
    load_val = 4'd0;

    // Reset for 2 cycles. On the second cycle, load and en are also asserted.
    run(1, 0, 0, 1, 1, 0);
    run(1, 1, 1, 1, 1, 12);
    chk("A_reset_q", 32'(q_o[0]), 32'd0);
    chk("A_reset_at_min", 32'(at_min_o[0]), 32'd1);
    chk("C_reset_over_load", 32'(q_o[2]), 32'd7);

    // Instance A (MAX 15, wrap) counts up 16 times with step 1.
    for (int k = 1; k <= 16; k++) begin
      run(0, 0, 1, 1, 1, 0);
      chk("A_up_q", 32'(q_o[0]), 32'(k % 16));
      chk("A_up_wrap", 32'(wrap_o[0]), 32'(k == 16));
    end
    run(0, 0, 1, 0, 1, 0);
    chk("A_dn1_q", 32'(q_o[0]), 32'd15);
    chk("A_dn1_wrap", 32'(wrap_o[0]), 32'd1);
    run(0, 0, 1, 0, 1, 0);
    chk("A_dn2_q", 32'(q_o[0]), 32'd14);

    // Instance B (MAX 9, wrap).
    run(0, 1, 0, 0, 0, 0);
    run(0, 0, 1, 0, 1, 0);
    chk("B_dn_from0_q", 32'(q_o[1]), 32'd9);
    chk("B_dn_from0_wrap", 32'(wrap_o[1]), 32'd1);
    run(0, 1, 0, 0, 0, 1);
    run(0, 0, 1, 0, 3, 0);
    chk("B_dn3_q", 32'(q_o[1]), 32'd8);
    chk("B_dn3_wrap", 32'(wrap_o[1]), 32'd1);
    run(0, 0, 1, 1, 4, 0);
    chk("B_up4_q", 32'(q_o[1]), 32'd2);
    chk("B_up4_wrap", 32'(wrap_o[1]), 32'd1);

    // Instance C (MAX 9, saturate).
    run(0, 1, 0, 0, 0, 7);
    run(0, 0, 1, 1, 5, 0);
    chk("C_up5_q", 32'(q_o[2]), 32'd9);
    chk("C_up5_sat", 32'(sat_o[2]), 32'd1);
    run(0, 0, 1, 1, 5, 0);
    chk("C_up_again_q", 32'(q_o[2]), 32'd9);
    chk("C_up_again_sat", 32'(sat_o[2]), 32'd1);
    run(0, 1, 0, 0, 0, 2);
    run(0, 0, 1, 0, 3, 0);
    chk("C_dn3_q", 32'(q_o[2]), 32'd0);
    chk("C_dn3_sat", 32'(sat_o[2]), 32'd1);
    run(0, 0, 1, 1, 9, 0);
    chk("C_exact_q", 32'(q_o[2]), 32'd9);
    chk("C_exact_sat", 32'(sat_o[2]), 32'd0);

    // Load has priority over en, and an out-of-range load_val is clamped.
    run(0, 1, 1, 1, 1, 12);
    chk("B_load_clamp_q", 32'(q_o[1]), 32'd9);
    chk("B_load_clamp_wrap", 32'(wrap_o[1]), 32'd0);

    // With en low, and with step 0, the count holds.
    for (int k = 0; k < 5; k++) begin
      run(0, 0, 0, 1, 1, 0);
      chk("B_en0_hold", 32'(q_o[1]), 32'd9);
    end
    for (int k = 0; k < 3; k++) begin
      run(0, 0, 1, 1, 0, 0);
      chk("B_step0_hold", 32'(q_o[1]), 32'd9);
    end

    // Reset lands on a cycle that would otherwise wrap.
    run(0, 1, 0, 1, 1, 9);
    run(1, 0, 1, 1, 1, 0);
    chk("B_rst_mid_q", 32'(q_o[1]), 32'd2);
    chk("B_rst_mid_wrap", 32'(wrap_o[1]), 32'd0);
    run(0, 0, 1, 1, 1, 0);
    chk("B_resume_q", 32'(q_o[1]), 32'd3);

    // Random traffic across all configurations.
    for (int k = 0; k < 2000; k++) begin
      run(($urandom_range(0, 63) == 0),
          ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                      : int'($urandom_range(0, 3)),
          int'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/updown_counter_mod.md
# updown_counter_mod

Parametrised up/down counter: configurable width, modulus, step size, wrap or saturate mode, synchronous load and count enable. It succeeds the fixed 4-bit up/down counter and is the general counting primitive for timers, address generators and position trackers. It has one synchronous clock domain and a fully registered count output.

## Interface
Parameters:
- WIDTH, 8: count width in bits, ≥ 2.
- MAX_VAL, 2**WIDTH-1: highest count value, 1 ≤ MAX_VAL ≤ 2**WIDTH-1. Counting is modulo MAX_VAL+1.
- RESET_VAL, 0: count value after reset, ≤ MAX_VAL.
- SATURATE, 0: 0 = wrap at the limits, 1 = clamp at the limits.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count enable.
- up_down  in  1  direction: 1 = up, 0 = down.
- step  in  WIDTH  increment/decrement amount. 0 means hold. Any value > MAX_VAL is treated as MAX_VAL.
- load  in  1  synchronous load, overrides en.
- load_val  in  WIDTH  value to load. Any value > MAX_VAL is clamped to MAX_VAL.
- q  out  WIDTH  registered count.
- wrap  out  1  registered one-cycle pulse: the last update crossed a limit while wrapping.
- sat  out  1  registered one-cycle pulse: the last update was clamped at a limit (SATURATE=1 only).
- at_max  out  1  combinational, (q == MAX_VAL).
- at_min  out  1  combinational, (q == 0).

## Operation
- Priority at each rising edge: reset > load > en > hold.
- Reset:
  - q ← RESET_VAL, wrap ← 0, sat ← 0.
  - Applies mid-count and overrides load and en in the same cycle.
- Load:
  - q ← min(load_val, MAX_VAL).
  - wrap ← 0, sat ← 0.
  - up_down, step and en are ignored.
- Count (en=1, load=0):
  - Let s = min(step, MAX_VAL).
  - All arithmetic is done at WIDTH+1 bits so no intermediate value overflows.
- Up, sum = q + s:
  - sum ≤ MAX_VAL: q ← sum.
  - sum > MAX_VAL and SATURATE=0: q ← sum − (MAX_VAL+1), wrap ← 1.
  - sum > MAX_VAL and SATURATE=1: q ← MAX_VAL, sat ← 1.
- Down:
  - q ≥ s: q ← q − s.
  - q < s and SATURATE=0: q ← q + (MAX_VAL+1) − s, wrap ← 1.
  - q < s and SATURATE=1: q ← 0, sat ← 1.
- Landing exactly on MAX_VAL (up) or on 0 (down) is not a wrap and not a saturation.
- Saturate mode, already at a limit and stepping further outward:
  - q stays at the limit.
  - sat pulses again on every such enabled cycle.
- en=1 with s=0: q holds, wrap=0, sat=0.
- en=0 and load=0: q holds, wrap ← 0, sat ← 0.
- wrap and sat are never both 1. sat is constant 0 when SATURATE=0.
- The design must meet the invariant q ≤ MAX_VAL at all times after the first reset.

## Timing
- Latency: the inputs sampled at edge N determine q, wrap and sat immediately after edge N.
- No combinational path from any input to q, wrap or sat.
- at_max and at_min follow q combinationally, in the same cycle as q.
- wrap and sat stay high for exactly one cycle per qualifying update. Back-to-back wrapping updates keep the pulse high on consecutive cycles.
- Direction may change on any cycle with no bubble. The new direction applies at the next enabled edge.
- Output state is undefined until the first reset edge.
- Throughput: one update per clock.

## Test plan
- Defaults (WIDTH=4, MAX_VAL=15, SATURATE=0), step=1:
  - reset for 2 cycles: q=0, at_min=1.
  - Count up 16 enabled cycles: q runs 1…15, then 0. wrap=1 only on the cycle q becomes 0.
  - Switch to down: 15, 14, ….
- MAX_VAL=9, SATURATE=0, count down from 0:
  - step=1: q=9, wrap=1.
  - step=3 from q=1: q=8, wrap=1.
  - Up with step=4 from q=8: q=2, wrap=1.
- MAX_VAL=9, SATURATE=1:
  - Up from q=7 with step=5: q=9, sat=1.
  - A further up step: q=9, sat=1 again.
  - Down from q=2 with step=3: q=0, sat=1.
  - step=9 from q=0 going up: q=9, sat=0 (exact landing).
- Load/enable priority:
  - load=1, en=1, load_val=12 with MAX_VAL=9: q=9, wrap=0.
  - load and reset together: q=RESET_VAL.
  - en=0 for 5 cycles: q constant.
  - step=0 with en=1: q constant.
- Reset mid-operation:
  - Assert reset during a wrapping cycle: q=RESET_VAL, wrap=0 after that edge.
  - Counting resumes from RESET_VAL on the next enabled edge.
- Randomised check against a reference model for 2000 cycles, covering both SATURATE settings, MAX_VAL=2**WIDTH−1 and MAX_VAL=5:
  - q ≤ MAX_VAL holds every cycle.
  - wrap and sat are never both 1.
